// File: rtl/gf180_ram_ctrl_pkg.sv
// Shared types and constants for the gf180 64x8 SRAM request controller.
// The CLEAR state is only reachable when CLEAR_ON_INIT_EN is defined.
package gf180_ram_ctrl_pkg;

    localparam int RAM_DEPTH       = 64;
    localparam int RAM_ADDR_W      = 6;
    localparam int RAM_DATA_W      = 8;
    localparam int MIN_INIT_CYCLES = 2;

    typedef enum logic [1:0] {
        INIT,
        CLEAR,
        READY
    } ctrl_state_e;

    typedef struct packed {
        logic                  cen;
        logic                  gwen;
        logic [RAM_DATA_W-1:0] wen;
    } ram_ctl_t;

    typedef struct packed {
        ram_ctl_t              ctl;
        logic [RAM_ADDR_W-1:0] a;
        logic [RAM_DATA_W-1:0] d;
    } ram_pins_t;

    localparam ram_ctl_t  RAM_CTL_IDLE   = '{cen: 1'b1, gwen: 1'b1, wen: '1};
    localparam ram_pins_t RAM_PINS_RESET = '{ctl: RAM_CTL_IDLE, a: '0, d: '0};

endpackage

// File: rtl/gf180_ram_pin_launch.sv
// Falling-edge pin register bank driving the SRAM macro inputs.
// Kept separate so the negedge domain can be constrained on its own.
module gf180_ram_pin_launch
    import gf180_ram_ctrl_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RST,
    input  ram_pins_t             stage,
    output logic                  ram_cen,
    output logic                  ram_gwen,
    output logic [RAM_DATA_W-1:0] ram_wen,
    output logic [RAM_ADDR_W-1:0] ram_a,
    output logic [RAM_DATA_W-1:0] ram_d
);

    ram_pins_t pins;

    // Launching half a cycle after the stage register gives the macro
    // half a period of both setup and hold around its sampling posedge.
    always_ff @(negedge CLK or posedge RST) begin
        if (RST) begin
            pins <= RAM_PINS_RESET;
        end else begin
            pins <= stage;
        end
    end

    assign ram_cen  = pins.ctl.cen;
    assign ram_gwen = pins.ctl.gwen;
    assign ram_wen  = pins.ctl.wen;
    assign ram_a    = pins.a;
    assign ram_d    = pins.d;

endmodule

// File: rtl/gf180_ram_64x8_ctrl.sv
// Valid/ready front end for the gf180_ram_64x8_wrapper macro: init sequencing,
// request staging and read-response capture. Optional macro: CLEAR_ON_INIT_EN.
module gf180_ram_64x8_ctrl
    import gf180_ram_ctrl_pkg::*;
#(
    parameter int INIT_CYCLES = 4,
    parameter int ADDR_W      = RAM_ADDR_W,
    parameter int DATA_W      = RAM_DATA_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [DATA_W-1:0] req_wmask,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              ram_cen,
    output logic              ram_gwen,
    output logic [DATA_W-1:0] ram_wen,
    output logic [ADDR_W-1:0] ram_a,
    output logic [DATA_W-1:0] ram_d,
    input  logic [DATA_W-1:0] ram_q
);

    localparam int INIT_LEN = (INIT_CYCLES < MIN_INIT_CYCLES) ? MIN_INIT_CYCLES : INIT_CYCLES;
    localparam int CNT_W    = $clog2(INIT_LEN);
    localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_LEN - 1);

    ctrl_state_e      state;
    ctrl_state_e      state_nxt;
    logic [CNT_W-1:0] init_cnt;
    ram_pins_t        stage;
    logic             stage_rd;
    logic             rd_q;
    logic             accept;
    logic             active;

    assign req_ready = (state == READY);
    assign accept    = req_valid && req_ready;
    // A zero-mask write is accepted but becomes an idle macro cycle.
    assign active    = accept && (!req_we || (req_wmask != '0));

`ifdef CLEAR_ON_INIT_EN
    logic [RAM_ADDR_W-1:0] clr_addr;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            clr_addr <= '0;
        end else if (state == CLEAR) begin
            clr_addr <= clr_addr + 1'b1;
        end
    end
`endif

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= INIT;
            init_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == INIT) begin
                init_cnt <= init_cnt + 1'b1;
            end
        end
    end

    // NOTE: defaulting state_nxt first keeps this block free of latches.
    always_comb begin
        state_nxt = state;
        case (state)
            INIT: begin
                if (init_cnt == INIT_LAST) begin
`ifdef CLEAR_ON_INIT_EN
                    state_nxt = CLEAR;
`else
                    state_nxt = READY;
`endif
                end
            end
`ifdef CLEAR_ON_INIT_EN
            CLEAR: begin
                if (clr_addr == RAM_ADDR_W'(RAM_DEPTH - 1)) begin
                    state_nxt = READY;
                end
            end
`endif
            READY:   state_nxt = READY;
            default: state_nxt = INIT;
        endcase
    end

    // Address and data only move on a real access, so idle cycles hold them.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stage    <= RAM_PINS_RESET;
            stage_rd <= 1'b0;
        end else begin
            stage.ctl <= RAM_CTL_IDLE;
            stage_rd  <= 1'b0;
            if (active) begin
                stage.ctl.cen <= 1'b0;
                stage.a       <= req_addr;
                if (req_we) begin
                    stage.ctl.gwen <= 1'b0;
                    stage.ctl.wen  <= ~req_wmask;
                    stage.d        <= req_wdata;
                end else begin
                    stage_rd <= 1'b1;
                end
            end
`ifdef CLEAR_ON_INIT_EN
            if (state == CLEAR) begin
                stage.ctl <= '{cen: 1'b0, gwen: 1'b0, wen: '0};
                stage.a   <= clr_addr;
                stage.d   <= '0;
            end
`endif
        end
    end

    // The macro samples a read at E1; Q is settled and captured at E2.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rd_q      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rd_q      <= stage_rd;
            rsp_valid <= rd_q;
            if (rd_q) begin
                rsp_rdata <= ram_q;
            end
        end
    end

    gf180_ram_pin_launch u_pin_launch (
        .CLK      (CLK),
        .RST      (RST),
        .stage    (stage),
        .ram_cen  (ram_cen),
        .ram_gwen (ram_gwen),
        .ram_wen  (ram_wen),
        .ram_a    (ram_a),
        .ram_d    (ram_d)
    );

endmodule

// File: tb/tb_gf180_ram_64x8_ctrl.sv
// Directed, table-driven bench for gf180_ram_64x8_ctrl with a behavioural
// 64x8 macro model that also watches pin setup/hold and the CEN init fall.
module tb_gf180_ram_64x8_ctrl;

    localparam int  PERIOD       = 60;
    localparam int  SETUP_T      = 5;
    localparam int  HOLD_T       = 5;
    localparam int  READY_CYCLES = 4;

    logic       CLK;
    logic       RST;
    logic       req_valid;
    logic       req_ready;
    logic       req_we;
    logic [5:0] req_addr;
    logic [7:0] req_wdata;
    logic [7:0] req_wmask;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       ram_cen;
    logic       ram_gwen;
    logic [7:0] ram_wen;
    logic [5:0] ram_a;
    logic [7:0] ram_d;
    logic [7:0] ram_q;

    int n_checks = 0;
    int n_fail   = 0;

    gf180_ram_64x8_ctrl #(.INIT_CYCLES(4)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wmask (req_wmask),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .ram_cen   (ram_cen),
        .ram_gwen  (ram_gwen),
        .ram_wen   (ram_wen),
        .ram_a     (ram_a),
        .ram_d     (ram_d),
        .ram_q     (ram_q)
    );

    initial CLK = 1'b0;
    always #(PERIOD / 2) CLK = ~CLK;

    // ---------------- macro model ----------------
    logic [7:0] mem [64];
    longint     last_pos  = -1000;
    longint     last_chg  = -1000;
    int         setup_err = 0;
    int         hold_err  = 0;
    int         init_err  = 0;
    int         hi_cnt    = 0;

    initial ram_q = 8'h00;

    always @(posedge CLK) begin
        if ($time - last_chg < SETUP_T) setup_err++;
        last_pos = $time;
        if (RST) begin
            hi_cnt = 0;
        end else if (ram_cen) begin
            hi_cnt++;
        end else begin
            if (hi_cnt < READY_CYCLES) init_err++;
            if (!ram_gwen) mem[ram_a] <= (mem[ram_a] & ram_wen) | (ram_d & ~ram_wen);
            else           ram_q <= mem[ram_a];
        end
    end

    always @(ram_cen, ram_gwen, ram_wen, ram_a, ram_d) begin
        if ($time - last_pos < HOLD_T) hold_err++;
        last_chg = $time;
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic vld, input logic we, input logic [5:0] addr,
                         input logic [7:0] wdata, input logic [7:0] wmask);
        req_valid = vld;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_wmask = wmask;
    endtask

    // Counts posedges after reset release until req_ready is seen; also
    // checks no response or CEN low appears during init.
    task automatic wait_ready(input string tag);
        int first;
        int early;
        first = 0;
        early = 0;
        for (int k = 1; k <= 200; k++) begin
            step();
            if (!ram_cen || rsp_valid) early++;
            if (req_ready) begin
                first = k;
                break;
            end
        end
        check({tag, "_ready_cycles"}, first, READY_CYCLES);
        check({tag, "_quiet_init"}, early, 0);
    endtask

    typedef struct {
        logic       vld;
        logic       we;
        logic [5:0] addr;
        logic [7:0] wdata;
        logic [7:0] wmask;
        logic       exp_cen;
        logic       exp_gwen;
        logic [7:0] exp_wen;
        logic [5:0] exp_a;
        logic [7:0] exp_d;
        logic       exp_rv;
        logic [7:0] exp_rd;
    } vec_t;

    function automatic vec_t mk(input logic vld, input logic we, input logic [5:0] addr,
                                input logic [7:0] wdata, input logic [7:0] wmask,
                                input logic cen, input logic gwen, input logic [7:0] wen,
                                input logic [5:0] a, input logic [7:0] d,
                                input logic rv, input logic [7:0] rd);
        vec_t v;
        v.vld = vld;   v.we = we;       v.addr = addr;   v.wdata = wdata; v.wmask = wmask;
        v.exp_cen = cen; v.exp_gwen = gwen; v.exp_wen = wen;
        v.exp_a = a;   v.exp_d = d;     v.exp_rv = rv;   v.exp_rd = rd;
        return v;
    endfunction

    vec_t vecs [20];

    initial begin : watchdog
        #(PERIOD * 5000);
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    initial begin : main
        // Row j drives a request; its expectations are the pins launched for
        // row j-2 and the response produced by row j-3.
        //             vld we addr  wdata  wmask | cen gwen wen   a      d     | rv  rdata
        vecs[0]  = mk(1, 1, 6'h05, 8'hA5, 8'hFF,  1, 1, 8'hFF, 6'h00, 8'h00,  0, 8'h00);
        vecs[1]  = mk(1, 0, 6'h05, 8'h00, 8'h00,  1, 1, 8'hFF, 6'h00, 8'h00,  0, 8'h00);
        vecs[2]  = mk(1, 1, 6'h10, 8'h3C, 8'hFF,  0, 0, 8'h00, 6'h05, 8'hA5,  0, 8'h00);
        vecs[3]  = mk(1, 1, 6'h10, 8'hFF, 8'h0F,  0, 1, 8'hFF, 6'h05, 8'hA5,  0, 8'h00);
        vecs[4]  = mk(1, 0, 6'h10, 8'h00, 8'h00,  0, 0, 8'h00, 6'h10, 8'h3C,  1, 8'hA5);
        vecs[5]  = mk(1, 1, 6'h00, 8'h11, 8'hFF,  0, 0, 8'hF0, 6'h10, 8'hFF,  0, 8'hA5);
        vecs[6]  = mk(1, 1, 6'h01, 8'h22, 8'hFF,  0, 1, 8'hFF, 6'h10, 8'hFF,  0, 8'hA5);
        vecs[7]  = mk(1, 1, 6'h02, 8'h33, 8'hFF,  0, 0, 8'h00, 6'h00, 8'h11,  1, 8'h3F);
        vecs[8]  = mk(1, 1, 6'h03, 8'h44, 8'hFF,  0, 0, 8'h00, 6'h01, 8'h22,  0, 8'h3F);
        vecs[9]  = mk(1, 0, 6'h00, 8'h00, 8'h00,  0, 0, 8'h00, 6'h02, 8'h33,  0, 8'h3F);
        vecs[10] = mk(1, 0, 6'h01, 8'h00, 8'h00,  0, 0, 8'h00, 6'h03, 8'h44,  0, 8'h3F);
        vecs[11] = mk(1, 0, 6'h02, 8'h00, 8'h00,  0, 1, 8'hFF, 6'h00, 8'h44,  0, 8'h3F);
        vecs[12] = mk(1, 0, 6'h03, 8'h00, 8'h00,  0, 1, 8'hFF, 6'h01, 8'h44,  1, 8'h11);
        vecs[13] = mk(1, 1, 6'h02, 8'h00, 8'h00,  0, 1, 8'hFF, 6'h02, 8'h44,  1, 8'h22);
        vecs[14] = mk(0, 0, 6'h00, 8'h00, 8'h00,  0, 1, 8'hFF, 6'h03, 8'h44,  1, 8'h33);
        vecs[15] = mk(0, 0, 6'h00, 8'h00, 8'h00,  1, 1, 8'hFF, 6'h03, 8'h44,  1, 8'h44);
        vecs[16] = mk(1, 0, 6'h02, 8'h00, 8'h00,  1, 1, 8'hFF, 6'h03, 8'h44,  0, 8'h44);
        vecs[17] = mk(0, 0, 6'h00, 8'h00, 8'h00,  1, 1, 8'hFF, 6'h03, 8'h44,  0, 8'h44);
        vecs[18] = mk(0, 0, 6'h00, 8'h00, 8'h00,  0, 1, 8'hFF, 6'h02, 8'h44,  0, 8'h44);
        vecs[19] = mk(0, 0, 6'h00, 8'h00, 8'h00,  1, 1, 8'hFF, 6'h02, 8'h44,  1, 8'h33);

        RST = 1'b1;
        drive(0, 0, 6'h00, 8'h00, 8'h00);
        #1;
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_rdata", rsp_rdata, 8'h00);
        check("rst_ram_cen",   ram_cen,   1);
        check("rst_ram_gwen",  ram_gwen,  1);
        check("rst_ram_wen",   ram_wen,   8'hFF);
        check("rst_ram_a",     ram_a,     6'h00);
        check("rst_ram_d",     ram_d,     8'h00);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        wait_ready("init");

        for (int j = 0; j < 20; j++) begin
            check($sformatf("v%0d_req_ready", j), req_ready, 1);
            check($sformatf("v%0d_ram_cen", j),   ram_cen,   vecs[j].exp_cen);
            check($sformatf("v%0d_ram_gwen", j),  ram_gwen,  vecs[j].exp_gwen);
            check($sformatf("v%0d_ram_wen", j),   ram_wen,   vecs[j].exp_wen);
            check($sformatf("v%0d_ram_a", j),     ram_a,     vecs[j].exp_a);
            check($sformatf("v%0d_ram_d", j),     ram_d,     vecs[j].exp_d);
            check($sformatf("v%0d_rsp_valid", j), rsp_valid, vecs[j].exp_rv);
            check($sformatf("v%0d_rsp_rdata", j), rsp_rdata, vecs[j].exp_rd);
            drive(vecs[j].vld, vecs[j].we, vecs[j].addr, vecs[j].wdata, vecs[j].wmask);
            step();
        end

        // Reset one cycle after a read is accepted: the read must vanish.
        drive(1, 0, 6'h01, 8'h00, 8'h00);
        step();
        drive(0, 0, 6'h00, 8'h00, 8'h00);
        #39;
        check("inflight_ram_cen", ram_cen, 0);
        check("inflight_ram_a",   ram_a,   6'h01);
        RST = 1'b1;
        #1;
        check("midrst_ram_cen",   ram_cen,   1);
        check("midrst_ram_gwen",  ram_gwen,  1);
        check("midrst_ram_wen",   ram_wen,   8'hFF);
        check("midrst_ram_a",     ram_a,     6'h00);
        check("midrst_ram_d",     ram_d,     8'h00);
        check("midrst_req_ready", req_ready, 0);
        check("midrst_rsp_rdata", rsp_rdata, 8'h00);
        begin
            int seen;
            seen = 0;
            for (int k = 0; k < 3; k++) begin
                step();
                if (rsp_valid) seen++;
            end
            check("midrst_no_rsp", seen, 0);
        end
        @(negedge CLK);
        RST = 1'b0;
        wait_ready("reinit");

        // Memory survives controller reset; a fresh read must still work.
        drive(1, 0, 6'h01, 8'h00, 8'h00);
        step();
        drive(0, 0, 6'h00, 8'h00, 8'h00);
        step();
        check("post_rst_rv_e1", rsp_valid, 0);
        step();
        check("post_rst_rv_e2", rsp_valid, 1);
        check("post_rst_rdata", rsp_rdata, 8'h22);
        step();
        check("post_rst_pulse", rsp_valid, 0);
        check("post_rst_hold",  rsp_rdata, 8'h22);
        repeat (2) step();

        check("macro_setup_err", setup_err, 0);
        check("macro_hold_err",  hold_err,  0);
        check("macro_init_err",  init_err,  0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
